// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and types for the register-file writeback slice.
//   ADW  : register address width (NREG = 2**ADW registers)
//   DPW  : data width
//   wb_entry_t : one buffered producer result (valid, destination, data)
//   wb_src_e   : writeback source identifiers; the value doubles as the
//                request/grant bit index used by rf_wb_arb
package rf_pkg;

  localparam int ADW  = 5;
  localparam int DPW  = 32;
  localparam int NREG = 2 ** ADW;

  typedef struct packed {
    logic           vld;
    logic [ADW-1:0] rd;
    logic [DPW-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_LSU = 1'b0,
    SRC_ALU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rf_wb_arb.sv
// rf_wb_arb: two-way round-robin arbiter for the writeback port.
// Ports:
//   clk, arst_n : clock, asynchronous active-low reset
//   req[1:0]    : request per source (bit 0 = LSU, bit 1 = ALU)
//   grant[1:0]  : one-hot grant, combinational on req and the pointer
// The pointer names the source that wins the next contention and only moves
// when both sources request; a lone requester is granted without touching it.
module rf_wb_arb
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       arst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  wb_src_e ptr_q;
  wb_src_e ptr_d;

  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    case (req)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        grant = (ptr_q == SRC_ALU) ? 2'b10 : 2'b01;
        ptr_d = (ptr_q == SRC_ALU) ? SRC_LSU : SRC_ALU;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) ptr_q <= SRC_LSU;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: writeback controller and pending-write scoreboard owning the
// register-file write port (addr_3 / we_3 / wd_3).
// Widths come from rf_pkg (ADW, DPW, NREG).
// Ports:
//   clk, arst_n                 : clock, asynchronous active-low reset
//   alu_vld/alu_rdy/alu_rd/alu_data : ALU result handshake
//   lsu_vld/lsu_rdy/lsu_rd/lsu_data : load result handshake
//   sb_set_vld, sb_set_addr     : issue stage marks a destination pending
//   rf_we, rf_waddr, rf_wdata   : registered register-file write port
//   pending[NREG-1:0]           : registered scoreboard bitmap
// Optional build macro RF_WB_BYPASS_EN adds byp_addr_1/2 inputs and
// byp_hit_1/2, byp_data_1/2 outputs that forward the write stage to readers
// during the cycle reg_file suppresses its reads.
module rf_wb_ctrl
  import rf_pkg::*;
(
  input  logic            clk,
  input  logic            arst_n,
  input  logic            alu_vld,
  output logic            alu_rdy,
  input  logic [ADW-1:0]  alu_rd,
  input  logic [DPW-1:0]  alu_data,
  input  logic            lsu_vld,
  output logic            lsu_rdy,
  input  logic [ADW-1:0]  lsu_rd,
  input  logic [DPW-1:0]  lsu_data,
  input  logic            sb_set_vld,
  input  logic [ADW-1:0]  sb_set_addr,
  output logic            rf_we,
  output logic [ADW-1:0]  rf_waddr,
  output logic [DPW-1:0]  rf_wdata,
  output logic [NREG-1:0] pending
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [ADW-1:0]  byp_addr_1,
  input  logic [ADW-1:0]  byp_addr_2,
  output logic            byp_hit_1,
  output logic            byp_hit_2,
  output logic [DPW-1:0]  byp_data_1,
  output logic [DPW-1:0]  byp_data_2
`endif
);

  wb_entry_t      hold_alu;
  wb_entry_t      hold_lsu;
  logic [1:0]     req;
  logic [1:0]     grant;
  logic           any_grant;
  logic [ADW-1:0] win_rd;
  logic [DPW-1:0] win_data;
  logic [NREG-1:0] pending_d;

  // Bit positions follow wb_src_e: bit 0 = LSU, bit 1 = ALU.
  assign req = {hold_alu.vld, hold_lsu.vld};

  rf_wb_arb u_arb (
    .clk    (clk),
    .arst_n (arst_n),
    .req    (req),
    .grant  (grant)
  );

  // A granted hold drains this edge, so it can take a new result in the same cycle.
  assign alu_rdy = ~hold_alu.vld | grant[1];
  assign lsu_rdy = ~hold_lsu.vld | grant[0];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hold_alu <= '0;
    end else if (alu_vld && alu_rdy) begin
      hold_alu <= '{vld: 1'b1, rd: alu_rd, data: alu_data};
    end else if (grant[1]) begin
      hold_alu.vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hold_lsu <= '0;
    end else if (lsu_vld && lsu_rdy) begin
      hold_lsu <= '{vld: 1'b1, rd: lsu_rd, data: lsu_data};
    end else if (grant[0]) begin
      hold_lsu.vld <= 1'b0;
    end
  end

  assign any_grant = |grant;
  assign win_rd    = grant[1] ? hold_alu.rd   : hold_lsu.rd;
  assign win_data  = grant[1] ? hold_alu.data : hold_lsu.data;

  // x0 results are consumed by the grant but never reach the port; addr/data
  // keep their previous values in that case.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (any_grant && (win_rd != '0)) begin
      rf_we    <= 1'b1;
      rf_waddr <= win_rd;
      rf_wdata <= win_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Set is applied after clear so a newly issued producer to the register
  // being written keeps it pending.
  always_comb begin
    pending_d = pending;
    if (rf_we) pending_d[rf_waddr] = 1'b0;
    if (sb_set_vld && (sb_set_addr != '0)) pending_d[sb_set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) pending <= '0;
    else         pending <= pending_d;
  end

`ifdef RF_WB_BYPASS_EN
  assign byp_hit_1  = rf_we && (rf_waddr == byp_addr_1) && (byp_addr_1 != '0);
  assign byp_hit_2  = rf_we && (rf_waddr == byp_addr_2) && (byp_addr_2 != '0);
  assign byp_data_1 = rf_wdata;
  assign byp_data_2 = rf_wdata;
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb_rf_wb_ctrl: self-checking bench for rf_wb_ctrl. Directed scenarios plus
// a randomized run compared against a behavioural model of the writeback
// rules (two result buffers, round-robin on contention, x0 suppression,
// set-wins scoreboard). Build with RF_WB_BYPASS_EN to cover the bypass ports.
module tb_rf_wb_ctrl;
  import rf_pkg::*;

  logic            clk = 1'b0;
  logic            arst_n;
  logic            alu_vld, lsu_vld, sb_set_vld;
  logic            alu_rdy, lsu_rdy;
  logic [ADW-1:0]  alu_rd, lsu_rd, sb_set_addr;
  logic [DPW-1:0]  alu_data, lsu_data;
  logic            rf_we;
  logic [ADW-1:0]  rf_waddr;
  logic [DPW-1:0]  rf_wdata;
  logic [NREG-1:0] pending;
`ifdef RF_WB_BYPASS_EN
  logic [ADW-1:0]  byp_addr_1, byp_addr_2;
  logic            byp_hit_1, byp_hit_2;
  logic [DPW-1:0]  byp_data_1, byp_data_2;
`endif

  int checks   = 0;
  int failures = 0;

  rf_wb_ctrl dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .alu_vld     (alu_vld),
    .alu_rdy     (alu_rdy),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_vld     (lsu_vld),
    .lsu_rdy     (lsu_rdy),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .sb_set_vld  (sb_set_vld),
    .sb_set_addr (sb_set_addr),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .pending     (pending)
`ifdef RF_WB_BYPASS_EN
    ,
    .byp_addr_1  (byp_addr_1),
    .byp_addr_2  (byp_addr_2),
    .byp_hit_1   (byp_hit_1),
    .byp_hit_2   (byp_hit_2),
    .byp_data_1  (byp_data_1),
    .byp_data_2  (byp_data_2)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: index 0 = LSU buffer, 1 = ALU buffer; m_ptr = source
  // that wins the next tie.
  bit              m_hv [2];
  logic [ADW-1:0]  m_hrd[2];
  logic [DPW-1:0]  m_hd [2];
  int              m_ptr;
  bit              m_we;
  logic [ADW-1:0]  m_waddr;
  logic [DPW-1:0]  m_wdata;
  logic [NREG-1:0] m_pend;

  function automatic int m_grant();
    if (m_hv[0] && m_hv[1]) return m_ptr;
    if (m_hv[0]) return 0;
    if (m_hv[1]) return 1;
    return -1;
  endfunction

  function automatic bit m_rdy(int s);
    return !m_hv[s] || (m_grant() == s);
  endfunction

  task automatic model_reset();
    m_hv[0] = 0; m_hv[1] = 0;
    m_hrd[0] = '0; m_hrd[1] = '0;
    m_hd[0] = '0; m_hd[1] = '0;
    m_ptr = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_pend = '0;
  endtask

  task automatic model_edge();
    int g;
    bit ra, rl;
    g  = m_grant();
    ra = m_rdy(1);
    rl = m_rdy(0);
    if (m_we) m_pend[m_waddr] = 1'b0;
    if (sb_set_vld && sb_set_addr != 0) m_pend[sb_set_addr] = 1'b1;
    if (g >= 0 && m_hrd[g] != 0) begin
      m_we = 1; m_waddr = m_hrd[g]; m_wdata = m_hd[g];
    end else begin
      m_we = 0;
    end
    if (m_hv[0] && m_hv[1]) m_ptr = 1 - m_ptr;
    if (alu_vld && ra) begin m_hv[1] = 1; m_hrd[1] = alu_rd; m_hd[1] = alu_data; end
    else if (g == 1) m_hv[1] = 0;
    if (lsu_vld && rl) begin m_hv[0] = 1; m_hrd[0] = lsu_rd; m_hd[0] = lsu_data; end
    else if (g == 0) m_hv[0] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_vld = 0; alu_rd = '0; alu_data = '0;
    lsu_vld = 0; lsu_rd = '0; lsu_data = '0;
    sb_set_vld = 0; sb_set_addr = '0;
`ifdef RF_WB_BYPASS_EN
    byp_addr_1 = '0; byp_addr_2 = '0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    arst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    arst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
      failures++;
      $display("FAIL reset_wport got we=%b addr=%0d data=%h exp we=0 addr=0 data=0", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (pending !== '0) begin
      failures++;
      $display("FAIL reset_pending got=%h exp=0", pending);
    end
    checks++;
    if (alu_rdy !== 1'b1 || lsu_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_rdy got alu=%b lsu=%b exp 1 1", alu_rdy, lsu_rdy);
    end
  endtask

  task automatic test_single_alu();
    do_reset();
    sb_set_vld = 1; sb_set_addr = 5'd5;
    tick();
    sb_set_vld = 0;
    checks++;
    if (pending[5] !== 1'b1) begin
      failures++;
      $display("FAIL single_set_pending got=%b exp=1", pending[5]);
    end
    alu_vld = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (alu_rdy !== 1'b1) begin
      failures++;
      $display("FAIL single_alu_rdy got=%b exp=1", alu_rdy);
    end
    tick();
    alu_vld = 0;
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL single_early_we got=%b exp=0", rf_we);
    end
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_write got we=%b addr=%0d data=%h exp we=1 addr=5 data=deadbeef", rf_we, rf_waddr, rf_wdata);
    end
`ifdef RF_WB_BYPASS_EN
    byp_addr_1 = 5'd5; byp_addr_2 = 5'd6;
    #1;
    checks++;
    if (byp_hit_1 !== 1'b1 || byp_data_1 !== 32'hDEADBEEF || byp_hit_2 !== 1'b0) begin
      failures++;
      $display("FAIL bypass_hit got hit1=%b data1=%h hit2=%b exp 1 deadbeef 0", byp_hit_1, byp_data_1, byp_hit_2);
    end
    byp_addr_1 = '0; byp_addr_2 = '0;
`endif
    tick();
    checks++;
    if (rf_we !== 1'b0 || pending[5] !== 1'b0) begin
      failures++;
      $display("FAIL single_after got we=%b pend5=%b exp 0 0", rf_we, pending[5]);
    end
  endtask

  task automatic test_contention();
    logic [ADW-1:0] exp_a [4];
    logic [DPW-1:0] exp_d [4];
    exp_a = '{5'd2, 5'd1, 5'd1, 5'd2};
    exp_d = '{32'h22, 32'h11, 32'h11, 32'h22};
    do_reset();
    for (int r = 0; r < 2; r++) begin
      alu_vld = 1; alu_rd = 5'd1; alu_data = 32'h11;
      lsu_vld = 1; lsu_rd = 5'd2; lsu_data = 32'h22;
      tick();
      idle_inputs();
      for (int k = 0; k < 2; k++) begin
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== exp_a[2*r+k] || rf_wdata !== exp_d[2*r+k]) begin
          failures++;
          $display("FAIL contention_%0d_%0d got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                   r, k, rf_we, rf_waddr, rf_wdata, exp_a[2*r+k], exp_d[2*r+k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int ai = 0;
    logic [ADW-1:0] alu_seen[$];
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (rf_we && rf_waddr >= 10 && rf_waddr <= 13) alu_seen.push_back(rf_waddr);
      alu_vld = (ai < 4); alu_rd = ADW'(10 + ai); alu_data = 32'h100 + ai;
      lsu_vld = 1; lsu_rd = 5'd20; lsu_data = 32'h200 + c;
      #1;
      checks++;
      if (alu_rdy !== m_rdy(1) || lsu_rdy !== m_rdy(0)) begin
        failures++;
        $display("FAIL bp_rdy c=%0d got alu=%b lsu=%b exp alu=%b lsu=%b", c, alu_rdy, lsu_rdy, m_rdy(1), m_rdy(0));
      end
      if (alu_vld && m_rdy(1)) ai++;
      tick();
      checks++;
      if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
        failures++;
        $display("FAIL bp_write c=%0d got we=%b addr=%0d data=%h exp we=%b addr=%0d data=%h",
                 c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
      end
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      if (rf_we && rf_waddr >= 10 && rf_waddr <= 13) alu_seen.push_back(rf_waddr);
      tick();
    end
    checks++;
    if (alu_seen.size() != 4 || alu_seen[0] !== 5'd10 || alu_seen[1] !== 5'd11 ||
        alu_seen[2] !== 5'd12 || alu_seen[3] !== 5'd13) begin
      failures++;
      $display("FAIL bp_alu_order got count=%0d exp 4 writes to x10..x13 in order", alu_seen.size());
    end
  endtask

  task automatic test_x0();
    do_reset();
    sb_set_vld = 1; sb_set_addr = 5'd3;
    tick();
    sb_set_vld = 0;
    lsu_vld = 1; lsu_rd = '0; lsu_data = 32'hFFFFFFFF;
    #1;
    checks++;
    if (lsu_rdy !== 1'b1) begin
      failures++;
      $display("FAIL x0_rdy got=%b exp=1", lsu_rdy);
    end
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (rf_we !== 1'b0 || pending !== 32'h8) begin
        failures++;
        $display("FAIL x0_suppress c=%0d got we=%b pend=%h exp we=0 pend=00000008", c, rf_we, pending);
      end
    end
  endtask

  task automatic test_sb_race();
    do_reset();
    sb_set_vld = 1; sb_set_addr = 5'd7;
    tick();
    sb_set_vld = 0;
    alu_vld = 1; alu_rd = 5'd7; alu_data = 32'h77;
    tick();
    idle_inputs();
    tick();
    sb_set_vld = 1; sb_set_addr = 5'd7;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
      failures++;
      $display("FAIL race_write got we=%b addr=%0d exp we=1 addr=7", rf_we, rf_waddr);
    end
    tick();
    sb_set_vld = 0;
    checks++;
    if (pending[7] !== 1'b1) begin
      failures++;
      $display("FAIL race_set_wins got=%b exp=1", pending[7]);
    end
    alu_vld = 1; alu_rd = 5'd7; alu_data = 32'h78;
    tick();
    idle_inputs();
    tick();
    tick();
    checks++;
    if (pending[7] !== 1'b0) begin
      failures++;
      $display("FAIL race_clear got=%b exp=0", pending[7]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sb_set_vld = 1; sb_set_addr = 5'd9;
    alu_vld = 1; alu_rd = 5'd4; alu_data = 32'hA4;
    lsu_vld = 1; lsu_rd = 5'd6; lsu_data = 32'hB6;
    tick();
    alu_rd = 5'd8; alu_data = 32'hA8;
    lsu_rd = 5'd10; lsu_data = 32'hBA;
    tick();
    idle_inputs();
    #2;
    arst_n = 0;
    model_reset();
    #1;
    checks++;
    if (rf_we !== 1'b0 || pending !== '0) begin
      failures++;
      $display("FAIL midreset_clear got we=%b pend=%h exp we=0 pend=0", rf_we, pending);
    end
    @(negedge clk);
    arst_n = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (rf_we !== 1'b0) begin
        failures++;
        $display("FAIL midreset_stale c=%0d got we=%b addr=%0d exp we=0", c, rf_we, rf_waddr);
      end
    end
  endtask

  task automatic test_random();
    int acc_cnt = 0;
    int wr_cnt  = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata || pending !== m_pend) begin
        failures++;
        $display("FAIL rand_state c=%0d got we=%b addr=%0d data=%h pend=%h exp we=%b addr=%0d data=%h pend=%h",
                 c, rf_we, rf_waddr, rf_wdata, pending, m_we, m_waddr, m_wdata, m_pend);
      end
      if (rf_we) wr_cnt++;
      alu_vld     = ($urandom_range(0, 9) < 6);
      alu_rd      = ADW'($urandom_range(0, NREG - 1));
      alu_data    = $urandom;
      lsu_vld     = ($urandom_range(0, 9) < 6);
      lsu_rd      = ADW'($urandom_range(0, NREG - 1));
      lsu_data    = $urandom;
      sb_set_vld  = ($urandom_range(0, 3) == 0);
      sb_set_addr = ADW'($urandom_range(0, 7));
      #1;
      checks++;
      if (alu_rdy !== m_rdy(1) || lsu_rdy !== m_rdy(0)) begin
        failures++;
        $display("FAIL rand_rdy c=%0d got alu=%b lsu=%b exp alu=%b lsu=%b", c, alu_rdy, lsu_rdy, m_rdy(1), m_rdy(0));
      end
      if (alu_vld && m_rdy(1) && alu_rd != 0) acc_cnt++;
      if (lsu_vld && m_rdy(0) && lsu_rd != 0) acc_cnt++;
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      if (rf_we) wr_cnt++;
      tick();
    end
    checks++;
    if (wr_cnt != acc_cnt) begin
      failures++;
      $display("FAIL rand_conservation got writes=%0d exp accepted=%0d", wr_cnt, acc_cnt);
    end
  endtask

  initial begin
    arst_n = 0;
    idle_inputs();
    model_reset();
    test_reset();
    test_single_alu();
    test_contention();
    test_backpressure();
    test_x0();
    test_sb_race();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
